// File: rtl/status_spi_out.sv
// ----------------------------------------------------------------------------
// status_spi_out
//   SPI slave transmitter (mode 0, MSB first) that returns status/sample words
//   to the control MCU on MISO. Core logic queues one word at a time through a
//   single-entry holding register. The MCU drives NSS and SCK. Both are
//   asynchronous to clock and are synchronised here before edge detection.
//
// Ports
//   clock         in   1          system clock, rising edge
//   reset         in   1          synchronous, active-high
//   spi_nss       in   1          MCU chip select, active low (async)
//   spi_clock_in  in   1          MCU SCK, idle low (async)
//   spi_data_out  out  1          MISO
//   data_in       in   WORD_BITS  word to queue
//   data_load     in   1          1-cycle strobe, captures data_in
//   load_ready    out  1          holding register empty
//   data_sent     out  1          1-cycle pulse, full frame completed
//   underrun      out  1          1-cycle pulse, frame started with nothing queued
//   frame_error   out  1          1-cycle pulse, NSS rose before WORD_BITS SCK rises
//   dbg_state     out  1          current FSM state (0 = IDLE, 1 = SHIFT)
//
// Load handshake: data_load is a plain strobe with no back-pressure. load_ready
// is advisory only. A load while a word is already held overwrites it, and the
// latest word wins.
// ----------------------------------------------------------------------------
module status_spi_out #(
    parameter int                   WORD_BITS   = 16,
    parameter int                   SYNC_STAGES = 2,
    parameter logic [WORD_BITS-1:0] IDLE_WORD   = '0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 spi_nss,
    input  logic                 spi_clock_in,
    output logic                 spi_data_out,
    input  logic [WORD_BITS-1:0] data_in,
    input  logic                 data_load,
    output logic                 load_ready,
    output logic                 data_sent,
    output logic                 underrun,
    output logic                 frame_error,
    output logic                 dbg_state
);

    localparam int CW = $clog2(WORD_BITS + 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    state_e state_q, state_d;

    logic [SYNC_STAGES-1:0] nss_sync_q, sck_sync_q;
    logic                   nss_last_q, sck_last_q;
    logic [WORD_BITS-1:0]   shift_q, hold_q;
    logic                   hold_valid_q;
    logic [CW-1:0]          bit_count_q;
    logic                   data_sent_q, underrun_q, frame_error_q;

    logic nss_s, sck_s;
    logic nss_fall, nss_rise, sck_rise, sck_fall;
    logic last_bit;
    logic frame_start, frame_done, frame_abort, count_up, shift_en;

    // ------------------------------------------------------------------
    // Synchronisers plus one extra registered copy for edge detection.
    // NSS idles high and SCK idles low, so reset to those levels and no
    // spurious edge appears after reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            nss_sync_q <= '1;
            sck_sync_q <= '0;
            nss_last_q <= 1'b1;
            sck_last_q <= 1'b0;
        end else begin
            nss_sync_q[0] <= spi_nss;
            sck_sync_q[0] <= spi_clock_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                nss_sync_q[i] <= nss_sync_q[i-1];
                sck_sync_q[i] <= sck_sync_q[i-1];
            end
            nss_last_q <= nss_sync_q[SYNC_STAGES-1];
            sck_last_q <= sck_sync_q[SYNC_STAGES-1];
        end
    end

    assign nss_s    = nss_sync_q[SYNC_STAGES-1];
    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign nss_fall = nss_last_q & ~nss_s;
    assign nss_rise = ~nss_last_q & nss_s;
    assign sck_rise = ~sck_last_q & sck_s;
    assign sck_fall = sck_last_q & ~sck_s;

    // This SCK rise is the WORD_BITS-th one of the frame.
    assign last_bit = (bit_count_q == CW'(WORD_BITS - 1));

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (nss_fall) state_d = ST_SHIFT;
            ST_SHIFT: if ((sck_rise && last_bit) || nss_rise) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs and datapath controls.
    // Completion is checked before abort, so an NSS rise that coincides
    // with the final SCK rise still counts as a good frame.
    // ------------------------------------------------------------------
    always_comb begin
        frame_start  = 1'b0;
        frame_done   = 1'b0;
        frame_abort  = 1'b0;
        count_up     = 1'b0;
        shift_en     = 1'b0;
        spi_data_out = 1'b0;
        case (state_q)
            ST_IDLE: frame_start = nss_fall;
            ST_SHIFT: begin
                spi_data_out = shift_q[WORD_BITS-1];
                if (sck_rise && last_bit) frame_done  = 1'b1;
                else if (nss_rise)        frame_abort = 1'b1;
                else if (sck_rise)        count_up    = 1'b1;
                else if (sck_fall)        shift_en    = 1'b1;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: shift register, bit counter, holding register, pulses
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            shift_q       <= '0;
            hold_q        <= '0;
            hold_valid_q  <= 1'b0;
            bit_count_q   <= '0;
            data_sent_q   <= 1'b0;
            underrun_q    <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            if (frame_start) begin
                shift_q     <= hold_valid_q ? hold_q : IDLE_WORD;
                bit_count_q <= '0;
            end else if (count_up || frame_done) begin
                bit_count_q <= bit_count_q + CW'(1);
            end else if (shift_en) begin
                shift_q <= {shift_q[WORD_BITS-2:0], 1'b0};
            end

            // A load that coincides with frame start lands after the frame
            // has taken the old content, so the new word stays queued.
            if (data_load) begin
                hold_q       <= data_in;
                hold_valid_q <= 1'b1;
            end else if (frame_start) begin
                hold_valid_q <= 1'b0;
            end

            data_sent_q   <= frame_done;
            underrun_q    <= frame_start & ~hold_valid_q;
            frame_error_q <= frame_abort;
        end
    end

    assign load_ready  = ~hold_valid_q;
    assign data_sent   = data_sent_q;
    assign underrun    = underrun_q;
    assign frame_error = frame_error_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_status_spi_out.sv
module tb_status_spi_out;

  logic        clock;
  logic        reset;
  logic        spi_nss;
  logic        spi_clock_in;
  logic        spi_data_out;
  logic [15:0] data_in;
  logic        data_load;
  logic        load_ready;
  logic        data_sent;
  logic        underrun;
  logic        frame_error;
  logic        dbg_state;

  int total_cnt = 0;
  int bad_cnt   = 0;

  int cyc       = 0;
  int n_sent    = 0;
  int n_under   = 0;
  int n_err     = 0;
  int under_cyc = 0;
  int nss_cyc   = 0;
  logic lr_at_start;

  status_spi_out #(
    .WORD_BITS  (16),
    .SYNC_STAGES(2),
    .IDLE_WORD  (16'h0000)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .spi_nss     (spi_nss),
    .spi_clock_in(spi_clock_in),
    .spi_data_out(spi_data_out),
    .data_in     (data_in),
    .data_load   (data_load),
    .load_ready  (load_ready),
    .data_sent   (data_sent),
    .underrun    (underrun),
    .frame_error (frame_error),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  // pulse monitor, sampled away from the active edge
  always @(negedge clock) begin
    if (data_sent) n_sent++;
    if (frame_error) n_err++;
    if (underrun) begin
      n_under++;
      under_cyc = cyc;
    end
  end

  // ---------------- checking ----------------
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_load(input logic [15:0] w);
    data_in   = w;
    data_load = 1'b1;
    wait_clk(1);
    data_load = 1'b0;
  endtask

  // Mode-0 frame, SCK half-period 8 clocks. MISO is sampled just before each
  // SCK rise. Optionally loads a word in the frame-capture cycle, raises NSS
  // together with the last SCK rise, or adds SCK pulses after completion.
  task automatic run_frame(input int n_rise, input int extra, input bit nss_with_last,
                           input bit load_at_start, input logic [15:0] load_word,
                           output logic [15:0] rx, output int d_sent,
                           output int d_under, output int d_err, output int under_lat);
    int s0, u0, e0;
    s0 = n_sent; u0 = n_under; e0 = n_err;
    rx = '0;
    spi_nss = 1'b0;
    nss_cyc = cyc;
    if (load_at_start) begin
      // the detected NSS fall is acted on at the 3rd rising edge
      wait_clk(2);
      data_in   = load_word;
      data_load = 1'b1;
      wait_clk(1);
      data_load = 1'b0;
      wait_clk(5);
    end else begin
      wait_clk(8);
    end
    lr_at_start = load_ready;
    for (int i = 0; i < n_rise; i++) begin
      rx = {rx[14:0], spi_data_out};
      if (nss_with_last && i == n_rise - 1) spi_nss = 1'b1;
      spi_clock_in = 1'b1;
      wait_clk(8);
      spi_clock_in = 1'b0;
      wait_clk(8);
    end
    for (int i = 0; i < extra; i++) begin
      spi_clock_in = 1'b1;
      wait_clk(8);
      spi_clock_in = 1'b0;
      wait_clk(8);
    end
    spi_nss = 1'b1;
    wait_clk(8);
    d_sent    = n_sent - s0;
    d_under   = n_under - u0;
    d_err     = n_err - e0;
    under_lat = under_cyc - nss_cyc;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] rx;
    int ds, du, de, lat;

    reset        = 1'b1;
    spi_nss      = 1'b1;
    spi_clock_in = 1'b0;
    data_in      = '0;
    data_load    = 1'b0;
    wait_clk(3);
    reset = 1'b0;
    wait_clk(1);

    check_val("rst_miso",   spi_data_out, 0);
    check_val("rst_ready",  load_ready,   1);
    check_val("rst_sent",   data_sent,    0);
    check_val("rst_under",  underrun,     0);
    check_val("rst_ferr",   frame_error,  0);
    check_val("rst_state",  dbg_state,    0);

    // 1: basic frame
    do_load(16'hA5C3);
    check_val("t1_ready_loaded", load_ready, 0);
    run_frame(16, 0, 0, 0, 16'h0, rx, ds, du, de, lat);
    check_val("t1_rx",          rx,          16'hA5C3);
    check_val("t1_sent",        ds,          1);
    check_val("t1_under",       du,          0);
    check_val("t1_err",         de,          0);
    check_val("t1_ready_start", lr_at_start, 1);
    check_val("t1_state_end",   dbg_state,   0);

    // 2: underrun frame
    run_frame(16, 0, 0, 0, 16'h0, rx, ds, du, de, lat);
    check_val("t2_rx",     rx,  16'h0000);
    check_val("t2_under",  du,  1);
    check_val("t2_lat",    lat, 3);
    check_val("t2_sent",   ds,  1);

    // 3: overwrite, plus extra SCK pulses after completion
    do_load(16'h1234);
    wait_clk(2);
    do_load(16'hBEEF);
    run_frame(16, 2, 0, 0, 16'h0, rx, ds, du, de, lat);
    check_val("t3_rx",    rx, 16'hBEEF);
    check_val("t3_sent",  ds, 1);
    check_val("t3_under", du, 0);
    check_val("t3_err",   de, 0);

    // 4: abort after 7 rises, then a good frame
    do_load(16'hCAFE);
    run_frame(7, 0, 0, 0, 16'h0, rx, ds, du, de, lat);
    check_val("t4_rx7",   rx[6:0],    7'h65);
    check_val("t4_err",   de,         1);
    check_val("t4_sent",  ds,         0);
    check_val("t4_ready", load_ready, 1);
    do_load(16'h00FF);
    run_frame(16, 0, 0, 0, 16'h0, rx, ds, du, de, lat);
    check_val("t4b_rx",   rx, 16'h00FF);
    check_val("t4b_err",  de, 0);
    check_val("t4b_sent", ds, 1);

    // 5: load in the capture cycle
    do_load(16'h0F0F);
    run_frame(16, 0, 0, 1, 16'h5555, rx, ds, du, de, lat);
    check_val("t5_rx",          rx,          16'h0F0F);
    check_val("t5_ready_start", lr_at_start, 0);
    check_val("t5_ready_end",   load_ready,  0);
    run_frame(16, 0, 0, 0, 16'h0, rx, ds, du, de, lat);
    check_val("t5b_rx",    rx, 16'h5555);
    check_val("t5b_under", du, 0);

    // 7: NSS rise together with the 16th SCK rise completes the frame
    do_load(16'h8001);
    run_frame(16, 0, 1, 0, 16'h0, rx, ds, du, de, lat);
    check_val("t7_rx",   rx, 16'h8001);
    check_val("t7_sent", ds, 1);
    check_val("t7_err",  de, 0);

    // 6: reset mid-frame after 9 SCK rises
    do_load(16'h3C81);
    spi_nss = 1'b0;
    wait_clk(8);
    for (int i = 0; i < 9; i++) begin
      spi_clock_in = 1'b1;
      wait_clk(8);
      if (i == 4) do_load(16'h7777);
      if (i < 8) begin
        spi_clock_in = 1'b0;
        wait_clk(8);
      end
    end
    check_val("t6_pre_miso",  spi_data_out, 1);
    check_val("t6_pre_ready", load_ready,   0);
    check_val("t6_pre_state", dbg_state,    1);
    begin
      int s0, u0, e0;
      s0 = n_sent; u0 = n_under; e0 = n_err;
      reset        = 1'b1;
      spi_nss      = 1'b1;
      spi_clock_in = 1'b0;
      wait_clk(1);
      reset = 1'b0;
      wait_clk(1);
      check_val("t6_miso",  spi_data_out, 0);
      check_val("t6_ready", load_ready,   1);
      check_val("t6_sent",  data_sent,    0);
      check_val("t6_under", underrun,     0);
      check_val("t6_ferr",  frame_error,  0);
      check_val("t6_state", dbg_state,    0);
      wait_clk(8);
      check_val("t6_no_pulses", (n_sent - s0) + (n_under - u0) + (n_err - e0), 0);
    end
    run_frame(16, 0, 0, 0, 16'h0, rx, ds, du, de, lat);
    check_val("t6b_rx",    rx, 16'h0000);
    check_val("t6b_under", du, 1);
    check_val("t6b_sent",  ds, 1);
    check_val("t6b_err",   de, 0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
